// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forward-mux selects and the
// multiply/divide tracker state enum.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Wide enough for the largest legal MD_LATENCY (15).
  localparam int MD_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/hazard_scoreboard_md_tracker.sv
// Multiply/divide in-flight tracker: latency FSM, down-counter and the
// per-register pending vector that blocks readers of an unfinished result.
module md_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       md_start_e,
  input  logic [REG_ADDR_W-1:0]      md_dst_e,
  output logic [2**REG_ADDR_W-1:0]   pending,
  output logic                       md_busy,
  output logic                       md_done
);

  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 1);
  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(1);

  md_state_t             state;
  logic [MD_CNT_W-1:0]   cnt;
  logic [REG_ADDR_W-1:0] dst_q;
  logic                  accept;

  // A start is only taken when no op is still counting down.
  assign accept = md_start_e && (state != BUSY);

  always_ff @(posedge clk) begin
    if (accept) dst_q <= md_dst_e;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start_e) begin
            state   <= BUSY;
            cnt     <= CNT_LOAD;
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            md_done <= 1'b1;
          end
        end
        DONE: begin
          pending[dst_q] <= 1'b0;
          if (md_start_e) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end else begin
            state   <= IDLE;
            md_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Issued after the clear so a same-register restart keeps its bit.
      if (accept && (md_dst_e != '0)) pending[md_dst_e] <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && md_start_e && (state == BUSY))
      $error("md_tracker: md_start_e while busy is ignored");
  end
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load/branch/scoreboard stalls.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cnt / md_stall_cnt outputs.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  input  logic                  reg_write_e,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_to_reg_m,
  input  logic                  branch_d,
  input  logic                  md_op_d,
  input  logic                  md_start_e,
  input  logic [REG_ADDR_W-1:0] md_dst_e,
  output logic [1:0]            forward_ae,
  output logic [1:0]            forward_be,
  output logic                  forward_ad,
  output logic                  forward_bd,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_e,
  output logic                  md_busy,
  output logic                  md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           md_stall_cnt
`endif
);

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] wr_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] wr_w,
    input logic                  we_w
  );
    if ((src != '0) && (src == wr_m) && we_m) return FWD_MEM;
    if ((src != '0) && (src == wr_w) && we_w) return FWD_WB;
    return FWD_RF;
  endfunction

  logic [2**REG_ADDR_W-1:0] pending;
  logic lw_stall, br_stall, sb_stall, stall;
  logic br_hit_e, br_hit_m;

  md_tracker #(
    .REG_ADDR_W (REG_ADDR_W),
    .MD_LATENCY (MD_LATENCY)
  ) u_md_tracker (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (md_start_e),
    .md_dst_e   (md_dst_e),
    .pending    (pending),
    .md_busy    (md_busy),
    .md_done    (md_done)
  );

  assign forward_ae = fwd_sel(rs_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
  assign forward_be = fwd_sel(rt_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
  assign forward_ad = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m;
  assign forward_bd = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m;

  assign lw_stall = mem_to_reg_e && ((write_reg_e == rs_d) || (write_reg_e == rt_d));

  // r0 is hardwired zero, so a write to it never makes a branch operand stale.
  assign br_hit_e = reg_write_e && (write_reg_e != '0) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign br_hit_m = mem_to_reg_m && (write_reg_m != '0) &&
                    ((write_reg_m == rs_d) || (write_reg_m == rt_d));
  assign br_stall = branch_d && (br_hit_e || br_hit_m);

  assign sb_stall = pending[rs_d] || pending[rt_d] || (md_op_d && md_busy);

  assign stall   = lw_stall || br_stall || sb_stall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall_d)  stall_cnt    <= sat_inc(stall_cnt);
      if (sb_stall) md_stall_cnt <= sat_inc(md_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against an age-based reference model.
module tb_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk, reset;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [AW-1:0] write_reg_e, write_reg_m, write_reg_w, md_dst_e;
  logic          reg_write_e, reg_write_m, reg_write_w;
  logic          mem_to_reg_e, mem_to_reg_m, branch_d, md_op_d, md_start_e;
  logic [1:0]    forward_ae, forward_be;
  logic          forward_ad, forward_bd, stall_f, stall_d, flush_e, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cnt, md_stall_cnt;
  int unsigned   m_stall_cnt = 0;
  int unsigned   m_md_cnt = 0;
`endif

  hazard_scoreboard #(.REG_ADDR_W(AW), .MD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .md_op_d(md_op_d), .md_start_e(md_start_e), .md_dst_e(md_dst_e),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  // Reference: age = cycles since the in-flight op started (0 = none), mdst = its target.
  int age  = 0;
  int mdst = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input int src);
    if (src != 0 && src == int'(write_reg_m) && reg_write_m) return 2'b10;
    if (src != 0 && src == int'(write_reg_w) && reg_write_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_pend(input int r);
    return (age > 0) && (r == mdst) && (r != 0);
  endfunction

  function automatic bit m_sb();
    return m_pend(int'(rs_d)) || m_pend(int'(rt_d)) || (md_op_d && age > 0);
  endfunction

  function automatic bit m_stall();
    bit lw, br;
    lw = mem_to_reg_e && (write_reg_e == rs_d || write_reg_e == rt_d);
    br = branch_d &&
         ((reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
          (mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d)));
    return lw || br || m_sb();
  endfunction

  task automatic check_all();
    bit s;
    s = m_stall();
    check("forward_ae", forward_ae, m_fwd(int'(rs_e)));
    check("forward_be", forward_be, m_fwd(int'(rt_e)));
    check("forward_ad", forward_ad, rs_d != 0 && rs_d == write_reg_m && reg_write_m);
    check("forward_bd", forward_bd, rt_d != 0 && rt_d == write_reg_m && reg_write_m);
    check("stall_f", stall_f, s);
    check("stall_d", stall_d, s);
    check("flush_e", flush_e, s);
    check("md_busy", md_busy, age > 0);
    check("md_done", md_done, age == LAT);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("md_stall_cnt", md_stall_cnt, m_md_cnt);
`endif
  endtask

  task automatic model_reset();
    age = 0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_md_cnt = 0;
`endif
  endtask

  // Advance one clock: model sees the same inputs the DUT samples on the edge.
  task automatic tick();
    bit s, sb;
    s  = m_stall();
    sb = m_sb();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (s  && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (sb && m_md_cnt    != 32'hFFFF_FFFF) m_md_cnt++;
`endif
      if (md_start_e && (age == 0 || age == LAT)) begin
        age  = 1;
        mdst = int'(md_dst_e);
      end else if (age == LAT) begin
        age = 0;
      end else if (age > 0) begin
        age++;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0; md_dst_e = '0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; branch_d = 0; md_op_d = 0; md_start_e = 0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    check("rst_busy", md_busy, 0);
    check("rst_done", md_done, 0);
    check("rst_stall", stall_d, 0);
    check_all();
    tick();
    reset = 1'b1;

    // Forwarding priority: M over W, W once M stops writing.
    rs_e = 3; write_reg_m = 3; reg_write_m = 1; write_reg_w = 3; reg_write_w = 1;
    #1 check("fwd_ae_mem", forward_ae, 2'b10);
    reg_write_m = 0;
    #1 check("fwd_ae_wb", forward_ae, 2'b01);
    check_all();
    tick();

    // Load-use stall lasts only while the load sits in E.
    clear_inputs();
    mem_to_reg_e = 1; write_reg_e = 5; rt_d = 5;
    #1;
    check("lw_stall_f", stall_f, 1);
    check("lw_stall_d", stall_d, 1);
    check("lw_flush_e", flush_e, 1);
    tick();
    mem_to_reg_e = 0;
    #1 check("lw_release", stall_d, 0);
    tick();

    // Branch hazard on an E-stage producer; none through r0.
    clear_inputs();
    branch_d = 1; rs_d = 7; reg_write_e = 1; write_reg_e = 7;
    #1 check("br_stall", stall_d, 1);
    write_reg_e = 0; rs_d = 0;
    #1 check("br_r0", stall_d, 0);
    check_all();
    tick();

    // MD op to r9 with a dependent reader held in decode.
    clear_inputs();
    md_start_e = 1; md_dst_e = 9;
    #1 check_all();
    tick();
    md_start_e = 0; rs_d = 9;
    for (int i = 0; i < LAT; i++) begin
      #1;
      check("md_stall", stall_d, 1);
      check("md_done_t", md_done, i == LAT - 1);
      check_all();
      tick();
    end
    #1;
    check("md_release", stall_d, 0);
    check("md_idle", md_busy, 0);
    tick();

    // Restart to the same register in the DONE cycle.
    clear_inputs();
    md_start_e = 1; md_dst_e = 9;
    #1;
    tick();
    md_start_e = 0; rs_d = 9;
    repeat (LAT - 1) begin
      #1 check_all();
      tick();
    end
    md_start_e = 1; md_dst_e = 9;
    #1;
    check("b2b_done", md_done, 1);
    check_all();
    tick();
    md_start_e = 0;
    #1;
    check("b2b_busy", md_busy, 1);
    check("b2b_pend", stall_d, 1);
    check_all();
    tick();
    repeat (LAT) begin
      #1 check_all();
      tick();
    end

    // Reset mid-operation abandons the op.
    clear_inputs();
    md_start_e = 1; md_dst_e = 9;
    #1;
    tick();
    md_start_e = 0; rs_d = 9;
    #1 check_all();
    tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_mid_busy", md_busy, 0);
    check("rst_mid_pend", stall_d, 0);
    check_all();
    tick();
    reset = 1'b1;
    repeat (LAT + 2) begin
      #1 check("rst_no_done", md_done, 0);
      check_all();
      tick();
    end

    // Randomized traffic over a narrow register range to force collisions.
    repeat (600) begin
      reset = ($urandom_range(0, 99) != 0);
      if (!reset) model_reset();
      rs_d = AW'($urandom_range(0, 7));
      rt_d = AW'($urandom_range(0, 7));
      rs_e = AW'($urandom_range(0, 7));
      rt_e = AW'($urandom_range(0, 7));
      write_reg_e = AW'($urandom_range(0, 7));
      write_reg_m = AW'($urandom_range(0, 7));
      write_reg_w = AW'($urandom_range(0, 7));
      md_dst_e    = AW'($urandom_range(0, 7));
      reg_write_e  = 1'($urandom_range(0, 1));
      reg_write_m  = 1'($urandom_range(0, 1));
      reg_write_w  = 1'($urandom_range(0, 1));
      mem_to_reg_e = ($urandom_range(0, 3) == 0);
      mem_to_reg_m = ($urandom_range(0, 3) == 0);
      branch_d     = ($urandom_range(0, 2) == 0);
      md_op_d      = ($urandom_range(0, 3) == 0);
      md_start_e   = reset && (age == 0 || age == LAT) && ($urandom_range(0, 2) == 0);
      #1 check_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
